// File: rtl/mem_ctrl.sv
// mem_ctrl: on-chip instruction memory with a single-cycle fetch port, and a
// data port bridged to an external req/ack bus with wait states and timeout.
module mem_ctrl #(
   parameter int IMEM_WORDS = 4096,
   parameter int TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] mem_instr_addr,
   output logic [31:0] mem_instr_data,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wr_data,
   input  logic        mem_wr,
   input  logic        mem_rd,
   output logic [31:0] mem_rd_data,
   output logic        mem_valid,
   input  logic        imem_wr_en,
   input  logic [31:0] imem_wr_addr,
   input  logic [31:0] imem_wr_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err
);

   localparam int AW = $clog2(IMEM_WORDS);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   logic [31:0]   imem [IMEM_WORDS];
   logic [AW-1:0] f_idx;
   logic [AW-1:0] w_idx;
   logic          f_ok;
   logic          w_ok;
   logic          req;
   state_t        state;
   logic [15:0]   cnt;

   assign f_idx = mem_instr_addr[AW+1:2];
   assign w_idx = imem_wr_addr[AW+1:2];
   assign f_ok  = (mem_instr_addr >> (AW + 2)) == 32'd0;
   assign w_ok  = (imem_wr_addr >> (AW + 2)) == 32'd0;
   assign req   = mem_wr | mem_rd;

   // Contents survive reset; the load port is the only way to change them.
   always_ff @(posedge clk) begin
      if (imem_wr_en && w_ok)
         imem[w_idx] <= imem_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         mem_instr_data <= '0;
      else
         mem_instr_data <= f_ok ? imem[f_idx] : '0;
   end

   assign mem_valid = ((state == IDLE) & ~req) | (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bus_req     <= 1'b0;
         bus_we      <= 1'b0;
         bus_addr    <= '0;
         bus_wdata   <= '0;
         bus_err     <= 1'b0;
         mem_rd_data <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req) begin
                  bus_we    <= mem_wr;
                  bus_addr  <= mem_addr;
                  bus_wdata <= mem_wr_data;
                  cnt       <= '0;
                  bus_req   <= 1'b1;
                  state     <= BUS;
               end
            end
            BUS: begin
               if (bus_ack) begin
                  if (!bus_we)
                     mem_rd_data <= bus_rdata;
                  bus_req <= 1'b0;
                  state   <= DONE;
               end else if (cnt == TMO_LAST) begin
                  bus_err <= 1'b1;
                  if (!bus_we)
                     mem_rd_data <= 32'hDEADBEEF;
                  bus_req <= 1'b0;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized bench for mem_ctrl with a queue scoreboard on the
// data port and a behavioural bus responder.
module tb_mem_ctrl;

   localparam int IW = 16;
   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] mem_instr_addr = '0;
   logic [31:0] mem_instr_data;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wr_data = '0;
   logic        mem_wr = 1'b0;
   logic        mem_rd = 1'b0;
   logic [31:0] mem_rd_data;
   logic        mem_valid;
   logic        imem_wr_en = 1'b0;
   logic [31:0] imem_wr_addr = '0;
   logic [31:0] imem_wr_data = '0;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata = '0;
   logic        bus_ack;
   logic        bus_err;

   logic resp_ack = 1'b0;
   logic force_ack = 1'b0;
   assign bus_ack = resp_ack | force_ack;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          stall;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] imodel [IW];
   logic [31:0] m_rd = '0;
   logic        m_err = 1'b0;
   int          cur_delay = 0;
   logic [31:0] cur_rdata = '0;
   logic [31:0] cur_addr = '0;
   logic [31:0] cur_wdata = '0;
   logic        cur_we = 1'b0;
   logic        mon_en = 1'b0;

   mem_ctrl #(.IMEM_WORDS(IW), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .mem_instr_addr(mem_instr_addr),
      .mem_instr_data(mem_instr_data),
      .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data),
      .mem_wr(mem_wr),
      .mem_rd(mem_rd),
      .mem_rd_data(mem_rd_data),
      .mem_valid(mem_valid),
      .imem_wr_en(imem_wr_en),
      .imem_wr_addr(imem_wr_addr),
      .imem_wr_data(imem_wr_data),
      .bus_req(bus_req),
      .bus_we(bus_we),
      .bus_addr(bus_addr),
      .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata),
      .bus_ack(bus_ack),
      .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus slave: acks in the cur_delay-th request cycle (0 = never).
   initial begin
      int n;
      n = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus_req) begin
            n++;
            chk("bus_we", 32'(bus_we), 32'(cur_we));
            chk("bus_addr", bus_addr, cur_addr);
            if (cur_we)
               chk("bus_wdata", bus_wdata, cur_wdata);
            resp_ack = (n == cur_delay);
            bus_rdata = (n == cur_delay) ? cur_rdata : $urandom;
         end else begin
            n = 0;
            resp_ack = 1'b0;
         end
      end
   end

   // Monitor: each rise of mem_valid closes one data access.
   initial begin
      logic prev;
      int   low;
      exp_t e;
      prev = 1'b1;
      low = 0;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev = 1'b1;
            low = 0;
         end else if (!mem_valid) begin
            low++;
            prev = 1'b0;
         end else begin
            if (!prev) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done: got done expected none");
               end else begin
                  e = sb.pop_front();
                  chk("rd_data", mem_rd_data, e.rd);
                  chk("bus_err", 32'(bus_err), 32'(e.err));
                  chk("stall", 32'(low), 32'(e.stall));
               end
            end
            low = 0;
            prev = 1'b1;
         end
      end
   end

   task automatic access(input logic wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int dly);
      exp_t e;
      int   w;
      logic tmo;
      tmo = (dly == 0) || (dly > TO);
      cur_we = wr;
      cur_addr = addr;
      cur_wdata = wd;
      cur_delay = dly;
      cur_rdata = rdata;
      if (tmo) begin
         m_err = 1'b1;
         if (!wr)
            m_rd = 32'hDEADBEEF;
      end else if (!wr) begin
         m_rd = rdata;
      end
      e.rd = m_rd;
      e.err = m_err;
      e.stall = tmo ? TO + 1 : dly + 1;
      sb.push_back(e);
      mem_wr = wr;
      mem_rd = rd;
      mem_addr = addr;
      mem_wr_data = wd;
      w = 0;
      @(posedge clk);
      #1;
      while (!mem_valid && w < 50) begin
         @(posedge clk);
         #1;
         w++;
      end
      if (!mem_valid) begin
         checks++;
         failures++;
         $display("FAIL access_wait: got no done expected done");
      end
      mem_wr = 1'b0;
      mem_rd = 1'b0;
      mem_addr = $urandom;
      mem_wr_data = $urandom;
   endtask

   task automatic imem_load(input logic [31:0] a, input logic [31:0] d);
      imem_wr_en = 1'b1;
      imem_wr_addr = a;
      imem_wr_data = d;
      @(posedge clk);
      #1;
      imem_wr_en = 1'b0;
      if (a < 32'(4 * IW))
         imodel[(a >> 2) % IW] = d;
   endtask

   task automatic fetch(input logic [31:0] a);
      logic [31:0] exp;
      mem_instr_addr = a;
      exp = (a < 32'(4 * IW)) ? imodel[(a >> 2) % IW] : 32'd0;
      @(posedge clk);
      #1;
      chk("instr", mem_instr_data, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [31:0] old;
      logic        wr;
      #2;
      chk("rst_instr", mem_instr_data, 32'd0);
      chk("rst_rd_data", mem_rd_data, 32'd0);
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_we", 32'(bus_we), 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_err", 32'(bus_err), 32'd0);
      chk("rst_valid", 32'(mem_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < IW; i++)
         imem_load(32'(4 * i), (i < 4) ? 32'h11111111 * 32'(i + 1) : $urandom);
      old = imodel[0];
      imem_load(32'(4 * IW), 32'hBAD0BAD0);
      chk("oob_write", 32'(imodel[0]), 32'(old));
      fetch(32'd0);
      fetch(32'd4);
      fetch(32'd8);
      fetch(32'd12);
      fetch(32'(4 * IW));
      for (int i = 0; i < 12; i++)
         fetch(($urandom % 2 == 0) ? $urandom % (4 * IW) : $urandom);
      // Same-cycle read and write of one word returns the old word.
      a = 32'd21;
      mem_instr_addr = a;
      old = imodel[5];
      imem_wr_en = 1'b1;
      imem_wr_addr = 32'd20;
      imem_wr_data = 32'h5A5A1234;
      @(posedge clk);
      #1;
      imem_wr_en = 1'b0;
      chk("rw_old", mem_instr_data, old);
      imodel[5] = 32'h5A5A1234;
      fetch(a);

      mon_en = 1'b1;
      access(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, 32'h0, 3);
      access(1'b0, 1'b1, 32'h200, 32'h0, 32'h12345678, 1);
      access(1'b1, 1'b0, 32'h300, 32'h01020304, 32'h0, 2);
      access(1'b0, 1'b1, 32'h400, 32'h0, 32'h0, 0);
      access(1'b0, 1'b1, 32'h404, 32'h0, 32'h0BADF00D, 2);
      access(1'b1, 1'b1, 32'h500, 32'h55AA55AA, 32'h77777777, 1);
      access(1'b0, 1'b1, 32'h504, 32'h0, 32'hA5A5A5A5, TO);
      for (int i = 0; i < 40; i++) begin
         for (int g = 0; g < int'($urandom % 3); g++) begin
            force_ack = $urandom % 2 == 0;
            @(posedge clk);
            #1;
            force_ack = 1'b0;
         end
         wr = $urandom % 2 == 0;
         access(wr, wr ? 1'($urandom % 2) : 1'b1, $urandom, $urandom,
                $urandom, int'($urandom_range(0, 10)));
      end
      @(negedge clk);
      @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      mon_en = 1'b0;

      // Reset in the second bus cycle of a read.
      cur_we = 1'b0;
      cur_addr = 32'h600;
      cur_delay = 0;
      mem_addr = 32'h600;
      mem_rd = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("pre_rst_req", 32'(bus_req), 32'd1);
      rst_n = 1'b0;
      mem_rd = 1'b0;
      #1;
      chk("mid_rst_req", 32'(bus_req), 32'd0);
      chk("mid_rst_err", 32'(bus_err), 32'd0);
      chk("mid_rst_rd", mem_rd_data, 32'd0);
      chk("mid_rst_addr", bus_addr, 32'd0);
      chk("mid_rst_we", 32'(bus_we), 32'd0);
      chk("mid_rst_valid", 32'(mem_valid), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      force_ack = 1'b1;
      @(posedge clk);
      #1;
      force_ack = 1'b0;
      chk("post_ack_rd", mem_rd_data, 32'd0);
      chk("post_ack_req", 32'(bus_req), 32'd0);
      chk("post_ack_valid", 32'(mem_valid), 32'd1);
      chk("post_ack_err", 32'(bus_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller serving the CPU's two memory ports: a single-cycle instruction port backed by on-chip instruction memory, and a data port bridged to an external request/acknowledge bus with wait-state handling and timeout. It drives `mem_valid` so the hazard unit can stall the pipeline while a data access is outstanding. It sits between the CPU top and the system bus. It also owns the instruction-memory load port.

## Interface

**Parameters**
- `IMEM_WORDS`, 4096: instruction memory depth in 32-bit words (power of two).
- `TIMEOUT`, 255: bus cycles to wait for `bus_ack` before aborting (1..65535).

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `mem_instr_addr` in 32: CPU fetch byte address.
- `mem_instr_data` out 32: fetched instruction, registered.
- `mem_addr` in 32: CPU data byte address.
- `mem_wr_data` in 32: CPU store data.
- `mem_wr` in 1: store request.
- `mem_rd` in 1: load request.
- `mem_rd_data` out 32: load result, registered.
- `mem_valid` out 1: data port idle or access complete.
- `imem_wr_en` in 1: instruction memory load strobe.
- `imem_wr_addr` in 32: load byte address.
- `imem_wr_data` in 32: load word.
- `bus_req` out 1: external access request.
- `bus_we` out 1: 1 = write, 0 = read.
- `bus_addr` out 32: external address.
- `bus_wdata` out 32: external write data.
- `bus_rdata` in 32: external read data, valid with `bus_ack`.
- `bus_ack` in 1: external completion, single-cycle pulse.
- `bus_err` out 1: sticky timeout flag.

## Operation

**Instruction port**
- Word index = `mem_instr_addr[log2(IMEM_WORDS)+1:2]`. Address bits [1:0] are ignored.
- Each cycle, `mem_instr_data` <= imem[index]. If the address is ≥ 4*IMEM_WORDS, it loads 0 (NOP).
- If `imem_wr_en` is high, imem[`imem_wr_addr` index] <= `imem_wr_data`. Out-of-range writes are dropped.
- A read and a write to the same word in the same cycle return the old data.
- Memory contents are not cleared by reset.

**Data port FSM: IDLE, BUS, DONE**
- IDLE
  - If `mem_wr | mem_rd`: latch addr, wdata and we = `mem_wr`. A store wins if both are high. Clear the timeout counter and go to BUS.
- BUS
  - `bus_req`=1, with `bus_we`/`bus_addr`/`bus_wdata` driven from the latched values and held stable.
  - On `bus_ack`: for a read, `mem_rd_data` <= `bus_rdata`. Go to DONE.
  - Otherwise the counter increments. When counter == TIMEOUT-1 without ack: set `bus_err`; for a read, `mem_rd_data` <= 32'hDEADBEEF. Go to DONE.
- DONE
  - Go to IDLE unconditionally.
- `mem_valid` is combinational: (IDLE & ~(`mem_wr`|`mem_rd`)) | DONE. It drops in the same cycle a request appears.
- Requesters hold `mem_addr`/`mem_wr_data`/`mem_wr`/`mem_rd` stable until `mem_valid`=1. Changes during BUS are ignored.
- `bus_ack` outside BUS is ignored.
- `mem_rd_data` holds its last value across stores and idle cycles.
- `bus_err` clears only on reset.

**Reset values**
- `mem_instr_data`=0, `mem_rd_data`=0, `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0, `bus_err`=0, state = IDLE.
- `mem_valid` then follows its equation.
- Reset asserted mid-BUS drops `bus_req` immediately (asynchronously). A pending ack is lost and no write-back occurs.

## Timing

- Instruction fetch latency: 1 cycle (address at edge t, data after edge t+1).
- Data access, request first seen at cycle t:
  - t: state IDLE, `mem_valid`=0.
  - t+1: BUS, `bus_req`=1. Ack may arrive this same cycle.
  - With ack at cycle t+k (k≥1), DONE is at t+k+1 with `mem_valid`=1 and `mem_rd_data` already updated.
- Minimum access: 2 stall cycles.
- Timeout: DONE at t+TIMEOUT+1.
- Back-to-back: after DONE, the earliest next `bus_req` is 2 cycles later (IDLE then BUS).

## Test plan

- Load imem[0..3] = 0x11111111..0x44444444 via the load port, then fetch addrs 0,4,8,12 → data 0x11111111..0x44444444 each one cycle later. Fetch addr 4*IMEM_WORDS → 0.
- Store addr 0x100 data 0xCAFEF00D with ack 3 cycles after `bus_req` → `bus_req`/`bus_we`=1 for 3 cycles, `bus_addr`=0x100, `mem_valid` low 4 cycles, high for exactly 1 cycle in DONE.
- Load addr 0x200 with ack and `bus_rdata`=0x12345678 in the first BUS cycle → `mem_rd_data`=0x12345678 in DONE at t+2. The value is held through a subsequent store.
- No ack, TIMEOUT=8, read → `bus_req` high for 8 cycles, then `bus_err`=1, `mem_rd_data`=0xDEADBEEF, `mem_valid`=1. `bus_err` stays set through later successful accesses.
- `mem_wr` and `mem_rd` both high → `bus_we`=1, `mem_rd_data` unchanged.
- Deassert `rst_n` in the second BUS cycle → `bus_req`=0 immediately, all outputs at reset values. An ack arriving after reset releases causes no change.
